// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: RV32I load/store controller for a word-wide memory with a combinational read port.
// Byte and halfword stores are handled as a read-modify-write.
module mem_access_ctrl #(
    parameter int BIT_WIDTH   = 32,
    parameter int ENTRY_COUNT = 256,
    parameter int ADDR_WIDTH  = $clog2((BIT_WIDTH/8)*ENTRY_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [BIT_WIDTH-1:0]  req_wdata,
    output logic                  rsp_valid,
    output logic [BIT_WIDTH-1:0]  rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_readAddr,
    output logic [ADDR_WIDTH-1:0] mem_writeAddr,
    output logic [BIT_WIDTH-1:0]  mem_writeData,
    output logic                  mem_writeEn,
    input  logic [BIT_WIDTH-1:0]  mem_readData
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d, err_q, err_d;
    logic [2:0]            f3_q, f3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BIT_WIDTH-1:0]  wdata_q, wdata_d, rdata_q, rdata_d, word_q, word_d;
    logic [BIT_WIDTH-1:0]  merged, ld_val;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic                  bad;

    assign bad = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                 (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00) ||
                 (req_funct3 inside {3'b011, 3'b110, 3'b111}) ||
                 (req_we && req_funct3[2]);

    assign byte_sel = mem_readData[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = mem_readData[{addr_q[1], 4'b0000} +: 16];
    assign ld_val   = f3_q == 3'b000 ? {{24{byte_sel[7]}}, byte_sel} :
                      f3_q == 3'b100 ? {24'd0, byte_sel} :
                      f3_q == 3'b001 ? {{16{half_sel[15]}}, half_sel} :
                      f3_q == 3'b101 ? {16'd0, half_sel} : mem_readData;

    always_comb begin
        merged = word_q;
        if (f3_q == 3'b000)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        err_d   = err_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        word_d  = word_q;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d    = req_we;
                f3_d    = req_funct3;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                err_d   = bad;
                rdata_d = '0;
                state_d = bad ? RESP : ACCESS;
            end
            ACCESS: begin
                rdata_d = we_q ? '0 : ld_val;
                word_d  = mem_readData;
                state_d = (we_q && f3_q != 3'b010) ? MERGE_WR : RESP;
            end
            MERGE_WR: state_d = RESP;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            err_q   <= err_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            word_q  <= word_d;
        end
    end

    assign req_ready     = state_q == IDLE;
    assign rsp_valid     = state_q == RESP;
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;
    assign mem_readAddr  = addr_q >> 2;
    assign mem_writeAddr = addr_q >> 2;
    assign mem_writeEn   = (state_q == ACCESS && we_q && f3_q == 3'b010) || state_q == MERGE_WR;
    assign mem_writeData = state_q == MERGE_WR ? merged : wdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vector table plus reset-abort and back-to-back sequences,
// with a behavioural word memory attached to the controller.
module tb_mem_access_ctrl;
    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_ready, rsp_valid, rsp_err, mem_writeEn;
    logic [2:0]  req_funct3 = 3'b0;
    logic [9:0]  req_addr = '0, mem_readAddr, mem_writeAddr;
    logic [31:0] req_wdata = '0, rsp_rdata, mem_writeData, mem_readData;
    logic [31:0] mem [0:255];
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_readAddr(mem_readAddr), .mem_writeAddr(mem_writeAddr),
        .mem_writeData(mem_writeData), .mem_writeEn(mem_writeEn),
        .mem_readData(mem_readData)
    );

    assign mem_readData = mem[mem_readAddr[7:0]];
    always @(posedge clk) if (mem_writeEn) mem[mem_writeAddr[7:0]] <= mem_writeData;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        wen;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat, output logic wen);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wen = 1'b0; lat = 99; rdata = 'x; err = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            wen |= mem_writeEn;
            if (rsp_valid) begin
                lat = c; rdata = rsp_rdata; err = rsp_err;
                break;
            end
        end
    endtask

    vec_t        v [18];
    logic [31:0] r;
    logic        e, w;
    int          l;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        v[0]  = '{1'b1, 3'b010, 10'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1'b1};
        v[1]  = '{1'b0, 3'b010, 10'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1'b0};
        v[2]  = '{1'b1, 3'b010, 10'h10, 32'h11223344, 32'h0,        1'b0, 2, 1'b1};
        v[3]  = '{1'b1, 3'b000, 10'h12, 32'h000000AA, 32'h0,        1'b0, 3, 1'b1};
        v[4]  = '{1'b0, 3'b010, 10'h10, 32'h0,        32'h11AA3344, 1'b0, 2, 1'b0};
        v[5]  = '{1'b1, 3'b010, 10'h10, 32'h80FF7F01, 32'h0,        1'b0, 2, 1'b1};
        v[6]  = '{1'b0, 3'b000, 10'h13, 32'h0,        32'hFFFFFF80, 1'b0, 2, 1'b0};
        v[7]  = '{1'b0, 3'b100, 10'h13, 32'h0,        32'h00000080, 1'b0, 2, 1'b0};
        v[8]  = '{1'b0, 3'b001, 10'h12, 32'h0,        32'hFFFF80FF, 1'b0, 2, 1'b0};
        v[9]  = '{1'b0, 3'b101, 10'h10, 32'h0,        32'h00007F01, 1'b0, 2, 1'b0};
        v[10] = '{1'b0, 3'b010, 10'h11, 32'h0,        32'h0,        1'b1, 1, 1'b0};
        v[11] = '{1'b1, 3'b001, 10'h13, 32'hFFFF1234, 32'h0,        1'b1, 1, 1'b0};
        v[12] = '{1'b0, 3'b011, 10'h10, 32'h0,        32'h0,        1'b1, 1, 1'b0};
        v[13] = '{1'b1, 3'b100, 10'h10, 32'h55555555, 32'h0,        1'b1, 1, 1'b0};
        v[14] = '{1'b1, 3'b001, 10'h12, 32'h1234BEEF, 32'h0,        1'b0, 3, 1'b1};
        v[15] = '{1'b0, 3'b010, 10'h10, 32'h0,        32'hBEEF7F01, 1'b0, 2, 1'b0};
        v[16] = '{1'b0, 3'b000, 10'h10, 32'h0,        32'h00000001, 1'b0, 2, 1'b0};
        v[17] = '{1'b0, 3'b001, 10'h12, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 1'b0};

        #2;
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_wen", {31'd0, mem_writeEn}, 32'd0);
        check("reset_raddr", {22'd0, mem_readAddr}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            do_req(v[i].we, v[i].f3, v[i].addr, v[i].wdata, r, e, l, w);
            check($sformatf("v%0d_rdata", i), r, v[i].rdata);
            check($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, v[i].err});
            check($sformatf("v%0d_latency", i), l, v[i].lat);
            check($sformatf("v%0d_wen", i), {31'd0, w}, {31'd0, v[i].wen});
        end
        check("mem4_after_table", mem[4], 32'hBEEF7F01);

        // Reset during MERGE_WR of SH 0xBEEF to 0x10 must leave mem[4] alone.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 10'h10; req_wdata = 32'h0000BEEF;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort_wen_in_merge", {31'd0, mem_writeEn}, 32'd1);
        check("abort_wdata_in_merge", mem_writeData, 32'hBEEFBEEF);
        reset = 1'b1;
        #1;
        check("abort_wen_drop", {31'd0, mem_writeEn}, 32'd0);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_raddr", {22'd0, mem_readAddr}, 32'd0);
        check("abort_wdata", mem_writeData, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("reset_hold_ready", {31'd0, req_ready}, 32'd1);
            check("reset_hold_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("reset_no_accept", {31'd0, req_ready}, 32'd1);
        check("abort_mem4", mem[4], 32'hBEEF7F01);

        // Back-to-back LW 0x10 with req_valid held high.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 10'h10; req_wdata = '0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("b2b_ready%0d", i), {31'd0, req_ready}, (i == 0 || i == 3) ? 32'd1 : 32'd0);
            check($sformatf("b2b_rsp%0d", i), {31'd0, rsp_valid}, (i == 2 || i == 5) ? 32'd1 : 32'd0);
            if (i == 2 || i == 5) check($sformatf("b2b_rdata%0d", i), rsp_rdata, 32'hBEEF7F01);
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_idle_after", {31'd0, req_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32: data word width; only 32 is supported.
REQ-002 SHALL have parameter ENTRY_COUNT, default 256: number of words in the attached data memory.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2((BIT_WIDTH/8)*ENTRY_COUNT): byte-address width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1: CPU request present.
REQ-007 SHALL have port req_ready, output, 1: controller can accept a request.
REQ-008 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-009 SHALL have port req_funct3, input, 3: RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-010 SHALL have port req_addr, input, ADDR_WIDTH: byte address.
REQ-011 SHALL have port req_wdata, input, BIT_WIDTH: store data, right-justified.
REQ-012 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata, output, BIT_WIDTH: load result, extended per funct3.
REQ-014 SHALL have port rsp_err, output, 1: misaligned access or illegal funct3; valid with rsp_valid.
REQ-015 SHALL have port mem_readAddr, output, ADDR_WIDTH: word index to data memory.
REQ-016 SHALL have port mem_writeAddr, output, ADDR_WIDTH: word index to data memory.
REQ-017 SHALL have port mem_writeData, output, BIT_WIDTH: full word to write.
REQ-018 SHALL have port mem_writeEn, output, 1: memory write strobe.
REQ-019 SHALL have port mem_readData, input, BIT_WIDTH: combinational read data from memory.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, MERGE_WR, RESP.
REQ-021 SHALL assert req_ready only in IDLE; a request is accepted on an edge where req_valid && req_ready, capturing we, funct3, addr, wdata.
REQ-022 SHALL compute word index as captured addr >> 2, zero-extended to ADDR_WIDTH, and drive it on both mem_readAddr and mem_writeAddr.
REQ-023 SHALL flag an error on acceptance: H/HU with addr[0]=1, W with addr[1:0]!=0, any funct3 in {011,110,111}, or store with funct3 in {100,101}.
REQ-024 On an error request, SHALL go IDLE->RESP directly, with no memory access, rsp_err=1 and rsp_rdata=0.
REQ-025 Load: IDLE->ACCESS->RESP; in ACCESS, register the selected byte/halfword (lane from addr[1:0]), sign- or zero-extended, into rsp_rdata.
REQ-026 Word store: IDLE->ACCESS->RESP; in ACCESS, drive mem_writeEn=1 and mem_writeData=wdata.
REQ-027 B/H store: IDLE->ACCESS->MERGE_WR->RESP; in ACCESS, register mem_readData; in MERGE_WR, drive mem_writeEn=1 with that word, the addressed lane replaced by wdata[7:0] or wdata[15:0] and other lanes unchanged.
REQ-028 SHALL assert rsp_valid exactly one cycle (RESP), then return to IDLE; RESP->IDLE is unconditional (no back-pressure).
REQ-029 SHALL drive mem_writeEn combinationally from state, so it is 1 only in word-store ACCESS or MERGE_WR.
REQ-030 Latency SHALL be rsp_valid 2 cycles after the accept edge for loads and word stores, 3 for B/H stores, and 1 for errors.
REQ-031 Stores SHALL return rsp_rdata=0 and rsp_err=0.
REQ-032 SHALL ignore req_valid outside IDLE; a request held through busy cycles is accepted on the first IDLE cycle.

Reset
REQ-033 On reset assertion, SHALL immediately go to IDLE and drive req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_writeEn=0, and mem_readAddr/mem_writeAddr/mem_writeData=0, regardless of clk.
REQ-034 Reset mid-B/H-store SHALL abort with no write issued; the memory word is left unchanged.
REQ-035 A request presented while reset is high SHALL NOT be accepted.

Verification
REQ-036 Word store 0xDEADBEEF to addr 0x10, then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after accept.
REQ-037 With mem[4]=0x11223344: SB 0xAA to 0x12 -> mem[4]=0x11AA3344, written in MERGE_WR, rsp_valid 3 cycles after accept.
REQ-038 With mem[4]=0x80FF7F01: LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF; LHU 0x10 -> 0x00007F01.
REQ-039 LW 0x11, SH 0x13, funct3=011 -> each gives rsp_err=1, rsp_rdata=0, rsp_valid 1 cycle after accept, mem_writeEn never asserted.
REQ-040 Assert reset during MERGE_WR of SH 0xBEEF to 0x10 -> mem_writeEn drops immediately, mem[4] unchanged, req_ready=1.
REQ-041 Back-to-back requests with req_valid held high -> second accepted the cycle after the first's rsp_valid, and req_ready=0 throughout the busy cycles.
